// File: rtl/led_pulse_stretcher_pkg.sv
// led_pulse_stretcher_pkg: shared state encoding and counter sizing for the LED pulse stretcher
package led_pulse_stretcher_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_GAP = 2'd2} state_e;
  function automatic int cnt_width(input int hold, input int gap);
    return $clog2((hold > gap ? hold : gap) + 1);
  endfunction
endpackage

// File: rtl/led_stretch_chan.sv
// led_stretch_chan: one channel turning one-tick triggers into fixed on/off LED blinks with a queue
//   clk, rst     clock and asynchronous active-high reset
//   trig_i       one-tick trigger
//   led_o        registered LED drive
//   busy_o       channel blinking or has queued blinks
//   dropped_o    registered pulse when a trigger hits a full queue
module led_stretch_chan
  import led_pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int PEND_W      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic led_o,
  output logic busy_o,
  output logic dropped_o
);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_C = CW'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic led_q, dropped_q, dropped_d;
  logic last, sat;
  assign last = cnt_q == CW'(1);
  assign sat = pend_q == PEND_MAX;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    dropped_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (trig_i) begin
        state_d = ST_ON;
        cnt_d = HOLD_C;
      end
    end else if (state_q == ST_GAP && last) begin
      // End of gap: a queued blink wins; a trigger here either cancels the decrement or restarts.
      state_d = (pend_q != '0 || trig_i) ? ST_ON : ST_IDLE;
      cnt_d = (pend_q != '0 || trig_i) ? HOLD_C : '0;
      pend_d = (pend_q != '0 && !trig_i) ? pend_q - 1'b1 : pend_q;
    end else begin
      pend_d = (trig_i && !sat) ? pend_q + 1'b1 : pend_q;
      dropped_d = trig_i && sat;
      state_d = last ? ST_GAP : state_q;
      cnt_d = last ? GAP_C : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      led_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      led_q <= state_d == ST_ON;
      dropped_q <= dropped_d;
    end
  end
  assign led_o = led_q;
  assign busy_o = state_q != ST_IDLE || pend_q != '0;
  assign dropped_o = dropped_q;
endmodule

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: N independent trigger-to-visible-blink LED channels
//   clk, rst     clock and asynchronous active-high reset
//   trig_i[N]    one-tick trigger per channel
//   led_o[N]     registered LED drive per channel
//   busy_o[N]    channel active or has queued blinks
//   dropped_o[N] trigger lost to a full queue
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int N           = 4,
  parameter int HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int PEND_W      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] trig_i,
  output logic [N-1:0] led_o,
  output logic [N-1:0] busy_o,
  output logic [N-1:0] dropped_o
);
  for (genvar i = 0; i < N; i++) begin : g_chan
    led_stretch_chan #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .GAP_CYCLES (GAP_CYCLES),
      .PEND_W     (PEND_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .trig_i   (trig_i[i]),
      .led_o    (led_o[i]),
      .busy_o   (busy_o[i]),
      .dropped_o(dropped_o[i])
    );
  end
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: directed table-driven bench for led_pulse_stretcher
module tb_led_pulse_stretcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] trig = '0;
  logic [3:0] led, busy, dropped;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] trig;
    logic [3:0] led;
    logic [3:0] busy;
    logic [3:0] drop;
  } vec_t;
  vec_t vecs[30];

  led_pulse_stretcher #(.N(4), .HOLD_CYCLES(4), .GAP_CYCLES(3), .PEND_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .trig_i   (trig),
    .led_o    (led),
    .busy_o   (busy),
    .dropped_o(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] t);
    trig = t;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int k, input logic [3:0] t, input logic [3:0] l,
                         input logic [3:0] b, input logic [3:0] d);
    vecs[k].trig = t;
    vecs[k].led = l;
    vecs[k].busy = b;
    vecs[k].drop = d;
  endtask

  initial begin
    // ch0: single trig at edge 0; ch1: edges 0,2,5; ch2: held edges 0..5; ch3: edge 0 then restart at edge 7
    set_vec(0, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
    set_vec(1, 4'b0100, 4'b1111, 4'b1111, 4'b0000);
    set_vec(2, 4'b0110, 4'b1111, 4'b1111, 4'b0000);
    set_vec(3, 4'b0100, 4'b1111, 4'b1111, 4'b0000);
    set_vec(4, 4'b0100, 4'b0000, 4'b1111, 4'b0100);
    set_vec(5, 4'b0110, 4'b0000, 4'b1111, 4'b0100);
    set_vec(6, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    set_vec(7, 4'b1000, 4'b1110, 4'b1110, 4'b0000);
    for (int k = 8; k <= 10; k++) set_vec(k, 4'b0000, 4'b1110, 4'b1110, 4'b0000);
    for (int k = 11; k <= 13; k++) set_vec(k, 4'b0000, 4'b0000, 4'b1110, 4'b0000);
    for (int k = 14; k <= 17; k++) set_vec(k, 4'b0000, 4'b0110, 4'b0110, 4'b0000);
    for (int k = 18; k <= 20; k++) set_vec(k, 4'b0000, 4'b0000, 4'b0110, 4'b0000);
    for (int k = 21; k <= 24; k++) set_vec(k, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    for (int k = 25; k <= 27; k++) set_vec(k, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    for (int k = 28; k <= 29; k++) set_vec(k, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    check("reset_led", 0, led, 4'b0000);
    check("reset_busy", 0, busy, 4'b0000);
    check("reset_dropped", 0, dropped, 4'b0000);
    rst = 1'b0;

    for (int k = 0; k < 30; k++) begin
      step(vecs[k].trig);
      check("tbl_led", k, led, vecs[k].led);
      check("tbl_busy", k, busy, vecs[k].busy);
      check("tbl_dropped", k, dropped, vecs[k].drop);
    end

    // async reset mid-ON with two blinks queued on ch0
    step(4'b0001);
    step(4'b0001);
    step(4'b0001);
    check("pre_rst_led", 0, led, 4'b0001);
    #3 rst = 1'b1;
    #1;
    check("async_rst_led", 0, led, 4'b0000);
    check("async_rst_busy", 0, busy, 4'b0000);
    check("async_rst_dropped", 0, dropped, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(4'b0000);
      check("post_rst_led", k, led, 4'b0000);
      check("post_rst_busy", k, busy, 4'b0000);
    end
    step(4'b0001);
    check("new_blink_led", 0, led, 4'b0001);
    for (int k = 1; k < 9; k++) begin
      step(4'b0000);
      check("new_blink_led", k, led, k < 4 ? 4'b0001 : 4'b0000);
      check("new_blink_busy", k, busy, k < 7 ? 4'b0001 : 4'b0000);
    end

    // all channels triggered together must blink identically
    step(4'b1111);
    check("all_led", 0, led, 4'b1111);
    for (int k = 1; k < 9; k++) begin
      step(4'b0000);
      check("all_led", k, led, k < 4 ? 4'b1111 : 4'b0000);
      check("all_busy", k, busy, k < 7 ? 4'b1111 : 4'b0000);
      check("all_dropped", k, dropped, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
